// File: rtl/ip_checksum_arbiter.sv
// ip_checksum_arbiter: shares one checksum engine between N_REQ AXI-Stream
// packet sources. Round-robin arbitration per packet, the grant is held from
// the first beat to tlast, and each result is returned tagged with the index
// of the requester that produced it. Only one packet is in flight at a time.
//
// Handshake semantics (all streams): a beat transfers on a rising clk edge
// where tvalid and tready are both high. Once the source raises tvalid it keeps
// data stable until the transfer. The arbiter never makes its input ready
// depend on anything except the granted lane's engine ready.
//
// Optional feature: define IP_CSUM_ARB_UDP_EN to add axis_i_udp. A zero
// checksum from a UDP packet is then reported as 16'hFFFF.
module ip_checksum_arbiter #(
    parameter int N_REQ      = 4,
    parameter int AXIS_BYTES = 2,
    localparam int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int W         = AXIS_BYTES * 8
) (
    input  logic                 clk,
    input  logic                 sreset,
    output logic [N_REQ-1:0]     axis_i_tready,
    input  logic [N_REQ-1:0]     axis_i_tvalid,
    input  logic [N_REQ-1:0]     axis_i_tlast,
    input  logic [N_REQ*W-1:0]   axis_i_tdata,
`ifdef IP_CSUM_ARB_UDP_EN
    input  logic [N_REQ-1:0]     axis_i_udp,
`endif
    input  logic                 axis_e_tready,
    output logic                 axis_e_tvalid,
    output logic                 axis_e_tlast,
    output logic [W-1:0]         axis_e_tdata,
    output logic                 axis_r_tready,
    input  logic                 axis_r_tvalid,
    input  logic [15:0]          axis_r_csum,
    input  logic                 axis_o_tready,
    output logic                 axis_o_tvalid,
    output logic [15:0]          axis_o_csum,
    output logic [ID_W-1:0]      axis_o_tid,
    output logic [1:0]           fsm_state
);

    localparam int CW = ID_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RSLT = 2'd2
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] pick;
    logic            any_valid;
    logic [CW-1:0]   cand;
    logic            lane_valid;
    logic            lane_last;
    logic [W-1:0]    lane_data;
    logic            beat_hs;
    logic            res_hs;

`ifdef IP_CSUM_ARB_UDP_EN
    logic            first_beat;
    logic            udp_flag;
`endif

    // Round-robin search: first valid lane at or after rr_ptr, wrapping to 0.
    always_comb begin
        pick      = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr} + CW'(i);
            if (cand >= CW'(N_REQ)) begin
                cand = cand - CW'(N_REQ);
            end
            if (!any_valid && axis_i_tvalid[cand[ID_W-1:0]]) begin
                pick      = cand[ID_W-1:0];
                any_valid = 1'b1;
            end
        end
    end

    assign lane_valid = axis_i_tvalid[grant];
    assign lane_last  = axis_i_tlast[grant];
    assign lane_data  = axis_i_tdata[grant*W +: W];
    assign beat_hs    = (state == XFER) && lane_valid && axis_e_tready;
    assign res_hs     = (state == RSLT) && axis_r_tvalid && axis_o_tready;

    // Packet-level FSM: arbitrate in IDLE, forward beats in XFER, return result in RSLT.
    always_ff @(posedge clk) begin
        if (sreset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            grant  <= '0;
`ifdef IP_CSUM_ARB_UDP_EN
            first_beat <= 1'b0;
            udp_flag   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        grant <= pick;
                        state <= XFER;
`ifdef IP_CSUM_ARB_UDP_EN
                        first_beat <= 1'b1;
`endif
                    end
                end
                XFER: begin
                    if (beat_hs) begin
`ifdef IP_CSUM_ARB_UDP_EN
                        first_beat <= 1'b0;
                        if (first_beat) begin
                            udp_flag <= axis_i_udp[grant];
                        end
`endif
                        if (lane_last) begin
                            state <= RSLT;
                        end
                    end
                end
                RSLT: begin
                    if (res_hs) begin
                        rr_ptr <= (grant == ID_W'(N_REQ - 1)) ? '0 : grant + ID_W'(1);
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stream steering: only the granted lane is connected, and only in its phase.
    always_comb begin
        axis_i_tready = '0;
        axis_e_tvalid = 1'b0;
        axis_e_tlast  = 1'b0;
        axis_e_tdata  = lane_data;
        axis_r_tready = 1'b0;
        axis_o_tvalid = 1'b0;
        if (!sreset) begin
            case (state)
                XFER: begin
                    axis_e_tvalid        = lane_valid;
                    axis_e_tlast         = lane_last;
                    axis_i_tready[grant] = axis_e_tready;
                end
                RSLT: begin
                    axis_o_tvalid = axis_r_tvalid;
                    axis_r_tready = axis_o_tready;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef IP_CSUM_ARB_UDP_EN
    // UDP reserves 0x0000 for "no checksum", so a computed zero is sent as 0xFFFF.
    assign axis_o_csum = (udp_flag && (axis_r_csum == 16'h0000)) ? 16'hFFFF : axis_r_csum;
`else
    assign axis_o_csum = axis_r_csum;
`endif

    assign axis_o_tid = sreset ? '0 : grant;
    assign fsm_state  = state;

endmodule

// File: tb/tb_ip_checksum_arbiter.sv
// Testbench for ip_checksum_arbiter (N_REQ=4, 16-bit lanes) with a behavioural
// checksum engine and a packet-level reference model of the arbiter.
module tb_ip_checksum_arbiter;

  localparam int N = 4;
`ifdef IP_CSUM_ARB_UDP_EN
  localparam bit UDP_EN = 1'b1;
`else
  localparam bit UDP_EN = 1'b0;
`endif

  typedef logic [15:0] wq_t[$];

  logic        clk;
  logic        sreset;
  logic [3:0]  tready_v;
  logic [3:0]  tvalid_v;
  logic [3:0]  tlast_v;
  logic [63:0] tdata_v;
  logic [3:0]  udp_v;
  logic        e_tready, e_tvalid, e_tlast;
  logic [15:0] e_tdata;
  logic        r_tready, r_tvalid;
  logic [15:0] r_csum;
  logic        o_tready, o_tvalid;
  logic [15:0] o_csum;
  logic [1:0]  o_tid;
  logic [1:0]  fsm_state;

  logic        lv[N];
  logic        ll[N];
  logic        lu[N];
  logic [15:0] ld[N];
  logic        o_hold;

  int vectors = 0;
  int miscompares = 0;

  // scoreboard: {tid, csum} expected in grant order
  logic [17:0] exp_q[$];
  logic [1:0]  tid_log[$];
  logic [15:0] csum_log[$];

  // reference model state
  int  m_phase;
  int  m_rr;
  int  m_grant;
  logic m_first;
  logic m_udp;
  wq_t m_words;

  ip_checksum_arbiter #(.N_REQ(N), .AXIS_BYTES(2)) dut (
    .clk          (clk),
    .sreset       (sreset),
    .axis_i_tready(tready_v),
    .axis_i_tvalid(tvalid_v),
    .axis_i_tlast (tlast_v),
    .axis_i_tdata (tdata_v),
`ifdef IP_CSUM_ARB_UDP_EN
    .axis_i_udp   (udp_v),
`endif
    .axis_e_tready(e_tready),
    .axis_e_tvalid(e_tvalid),
    .axis_e_tlast (e_tlast),
    .axis_e_tdata (e_tdata),
    .axis_r_tready(r_tready),
    .axis_r_tvalid(r_tvalid),
    .axis_r_csum  (r_csum),
    .axis_o_tready(o_tready),
    .axis_o_tvalid(o_tvalid),
    .axis_o_csum  (o_csum),
    .axis_o_tid   (o_tid),
    .fsm_state    (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      tvalid_v[i]         = lv[i];
      tlast_v[i]          = ll[i];
      udp_v[i]            = lu[i];
      tdata_v[i*16 +: 16] = ld[i];
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  function automatic logic [15:0] csum16(input wq_t w);
    logic [15:0] acc;
    acc = 16'h0000;
    foreach (w[i]) acc = oc_add(acc, w[i]);
    return ~acc;
  endfunction

  function automatic wq_t rand_words(input int n);
    wq_t q;
    for (int i = 0; i < n; i++) q.push_back(16'($urandom_range(0, 65535)));
    return q;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left at posedge+1.
  task automatic send_pkt(input int l, input wq_t words, input logic udp,
                          input int drop_after, input int drop_len, input int gap_max);
    int tmo;
    for (int i = 0; i < words.size(); i++) begin
      lv[l] = 1'b1;
      ld[l] = words[i];
      ll[l] = (i == words.size() - 1);
      lu[l] = udp;
      tmo = 0;
      do begin
        @(negedge clk);
        tmo++;
      end while (!tready_v[l] && tmo < 3000);
      @(posedge clk); #1;
      lv[l] = 1'b0;
      ll[l] = 1'b0;
      if (tmo >= 3000) begin
        chk("drv_timeout", 32'(l), 32'hFFFF);
        return;
      end
      if (i == drop_after) repeat (drop_len) begin @(posedge clk); #1; end
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic do_reset();
    sreset = 1'b1;
    for (int i = 0; i < N; i++) begin lv[i] = 1'b0; ll[i] = 1'b0; end
    @(posedge clk); #1;
    sreset = 1'b0;
  endtask

  task automatic wait_results(input int n);
    int tmo;
    tmo = 0;
    while (tid_log.size() < n && tmo < 5000) begin
      @(negedge clk);
      tmo++;
    end
    if (tid_log.size() < n) chk("result_timeout", 32'(tid_log.size()), 32'(n));
    @(posedge clk); #1;
  endtask

  task automatic rand_lane(input int l);
    repeat (8) begin
      send_pkt(l, rand_words($urandom_range(1, 6)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? 0 : -1, $urandom_range(1, 4), 2);
      repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
    end
  endtask

  // ---------------- behavioural checksum engine ----------------
  initial begin : engine
    logic        hs_e, hs_r, lst, rst, pend;
    logic [15:0] d, acc, res;
    int          lat;
    e_tready = 1'b0; r_tvalid = 1'b0; r_csum = 16'h0;
    pend = 1'b0; acc = 16'h0; res = 16'h0; lat = 0;
    forever begin
      @(negedge clk);
      hs_e = e_tvalid && e_tready;
      hs_r = r_tvalid && r_tready;
      d    = e_tdata;
      lst  = e_tlast;
      rst  = sreset;
      @(posedge clk); #1;
      if (rst) begin
        acc = 16'h0; pend = 1'b0; r_tvalid = 1'b0;
      end else begin
        if (hs_r) r_tvalid = 1'b0;
        if (hs_e) begin
          acc = oc_add(acc, d);
          if (lst) begin
            res = ~acc; acc = 16'h0; pend = 1'b1; lat = $urandom_range(0, 3);
          end
        end else if (pend) begin
          if (lat == 0) begin
            r_tvalid = 1'b1; r_csum = res; pend = 1'b0;
          end else begin
            lat--;
          end
        end
      end
      e_tready = !pend && !r_tvalid && ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : downstream
    o_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      o_tready = o_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  initial begin : model
    logic [15:0] c, exp_o;
    logic [17:0] e;
    m_phase = 0; m_rr = 0; m_grant = 0; m_first = 1'b0; m_udp = 1'b0;
    forever begin
      @(negedge clk);
      if (sreset) begin
        chk("rst_tready", 32'(tready_v), 32'd0);
        chk("rst_e_valid", 32'(e_tvalid), 32'd0);
        chk("rst_r_ready", 32'(r_tready), 32'd0);
        chk("rst_o_valid", 32'(o_tvalid), 32'd0);
        chk("rst_tid", 32'(o_tid), 32'd0);
        m_phase = 0; m_rr = 0; m_grant = 0; m_udp = 1'b0;
        m_words.delete();
        exp_q.delete();
      end else if (m_phase == 0) begin
        chk("idle_tready", 32'(tready_v), 32'd0);
        chk("idle_e_valid", 32'(e_tvalid), 32'd0);
        chk("idle_o_valid", 32'(o_tvalid), 32'd0);
        chk("idle_r_ready", 32'(r_tready), 32'd0);
        if (tvalid_v != 4'd0) begin
          for (int k = 0; k < N; k++) begin
            if (tvalid_v[(m_rr + k) % N]) begin
              m_grant = (m_rr + k) % N;
              break;
            end
          end
          m_phase = 1;
          m_first = 1'b1;
        end
      end else if (m_phase == 1) begin
        chk("xfer_e_valid", 32'(e_tvalid), 32'(tvalid_v[m_grant]));
        if (tvalid_v[m_grant]) begin
          chk("xfer_e_data", 32'(e_tdata), 32'(ld[m_grant]));
          chk("xfer_e_last", 32'(e_tlast), 32'(tlast_v[m_grant]));
        end
        chk("xfer_tready", 32'(tready_v), e_tready ? (32'd1 << m_grant) : 32'd0);
        chk("xfer_o_valid", 32'(o_tvalid), 32'd0);
        chk("xfer_r_ready", 32'(r_tready), 32'd0);
        if (tvalid_v[m_grant] && e_tready) begin
          if (m_first) m_udp = udp_v[m_grant];
          m_first = 1'b0;
          m_words.push_back(ld[m_grant]);
          if (tlast_v[m_grant]) begin
            c = csum16(m_words);
            if (UDP_EN && m_udp && c == 16'h0000) c = 16'hFFFF;
            exp_q.push_back({2'(m_grant), c});
            m_words.delete();
            m_phase = 2;
          end
        end
      end else begin
        chk("rslt_tready", 32'(tready_v), 32'd0);
        chk("rslt_e_valid", 32'(e_tvalid), 32'd0);
        chk("rslt_o_valid", 32'(o_tvalid), 32'(r_tvalid));
        chk("rslt_r_ready", 32'(r_tready), 32'(o_tready));
        chk("rslt_tid", 32'(o_tid), 32'(m_grant));
        if (o_tvalid) begin
          exp_o = (UDP_EN && m_udp && r_csum == 16'h0000) ? 16'hFFFF : r_csum;
          chk("rslt_csum", 32'(o_csum), 32'(exp_o));
        end
        if (o_tvalid && o_tready) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected", 32'(o_tid), 32'hFFFF);
          end else begin
            e = exp_q.pop_front();
            chk("sb_tid", 32'(o_tid), 32'(e[17:16]));
            chk("sb_csum", 32'(o_csum), 32'(e[15:0]));
          end
          tid_log.push_back(o_tid);
          csum_log.push_back(o_csum);
          m_rr = (m_grant + 1) % N;
          m_phase = 0;
        end
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  initial begin : main
    wq_t hdr, pa, pb;
    int  base, tmo, cnt;
    int  exp_order[5];
    logic [15:0] held_csum;
    logic [1:0]  held_tid;

    for (int i = 0; i < N; i++) begin
      lv[i] = 1'b0; ll[i] = 1'b0; lu[i] = 1'b0; ld[i] = 16'h0;
    end
    o_hold = 1'b0;
    sreset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sreset = 1'b0;

    // 1: single IPv4 header on lane 0
    hdr = '{16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011,
            16'h0000, 16'hc0a8, 16'h0001, 16'hc0a8, 16'h00c7};
    chk("model_hdr_csum", 32'(csum16(hdr)), 32'h0000B861);
    base = tid_log.size();
    send_pkt(0, hdr, 1'b0, -1, 0, 0);
    wait_results(base + 1);
    if (tid_log.size() > base) begin
      chk("t1_csum", 32'(csum_log[base]), 32'h0000B861);
      chk("t1_tid", 32'(tid_log[base]), 32'd0);
    end

    // 2: all lanes valid together, lane 0 has two packets
    do_reset();
    exp_order = '{0, 1, 2, 3, 0};
    base = tid_log.size();
    fork
      begin
        send_pkt(0, rand_words(3), 1'b0, -1, 0, 0);
        send_pkt(0, rand_words(2), 1'b0, -1, 0, 0);
      end
      send_pkt(1, rand_words(4), 1'b0, -1, 0, 0);
      send_pkt(2, rand_words(1), 1'b0, -1, 0, 0);
      send_pkt(3, rand_words(5), 1'b0, -1, 0, 0);
    join
    wait_results(base + 5);
    for (int i = 0; i < 5; i++) begin
      if (tid_log.size() > base + i) chk("t2_order", 32'(tid_log[base + i]), 32'(exp_order[i]));
    end

    // 3: lane 2 stalls mid-packet while lane 1 waits
    do_reset();
    base = tid_log.size();
    fork
      send_pkt(2, rand_words(4), 1'b0, 0, 5, 0);
      begin
        repeat (2) begin @(posedge clk); #1; end
        send_pkt(1, rand_words(2), 1'b0, -1, 0, 0);
      end
    join
    wait_results(base + 2);
    if (tid_log.size() >= base + 2) begin
      chk("t3_first", 32'(tid_log[base]), 32'd2);
      chk("t3_second", 32'(tid_log[base + 1]), 32'd1);
    end

    // 4: downstream back-pressure in RSLT
    o_hold = 1'b1;
    base = tid_log.size();
    send_pkt(0, rand_words(3), 1'b0, -1, 0, 0);
    tmo = 0;
    do begin @(negedge clk); tmo++; end while (!o_tvalid && tmo < 500);
    chk("t4_o_valid_seen", 32'(o_tvalid), 32'd1);
    held_csum = o_csum;
    held_tid  = o_tid;
    chk("t4_tid", 32'(held_tid), 32'd0);
    repeat (10) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(o_tvalid), 32'd1);
      chk("t4_hold_csum", 32'(o_csum), 32'(held_csum));
      chk("t4_hold_tid", 32'(o_tid), 32'(held_tid));
      chk("t4_hold_tready", 32'(tready_v), 32'd0);
    end
    @(posedge clk); #1;
    o_hold = 1'b0;
    wait_results(base + 1);

    // 5: reset in the middle of a lane 3 packet
    do_reset();
    base = tid_log.size();
    send_pkt(2, rand_words(2), 1'b0, -1, 0, 0);
    wait_results(base + 1);
    lv[3] = 1'b1; ld[3] = 16'h1234; ll[3] = 1'b0;
    cnt = 0; tmo = 0;
    while (cnt < 2 && tmo < 500) begin
      @(negedge clk);
      if (tready_v[3]) cnt++;
      tmo++;
      @(posedge clk); #1;
      ld[3] = ld[3] + 16'h1111;
    end
    chk("t5_partial_beats", 32'(cnt), 32'd2);
    sreset = 1'b1;
    lv[3] = 1'b0;
    @(posedge clk); #1;
    sreset = 1'b0;
    pa = rand_words(3);
    pb = rand_words(2);
    base = tid_log.size();
    fork
      send_pkt(2, pa, 1'b0, -1, 0, 0);
      send_pkt(3, pb, 1'b0, -1, 0, 0);
    join
    wait_results(base + 2);
    if (tid_log.size() >= base + 2) begin
      chk("t5_tid_first", 32'(tid_log[base]), 32'd2);
      chk("t5_csum_first", 32'(csum_log[base]), 32'(csum16(pa)));
      chk("t5_tid_second", 32'(tid_log[base + 1]), 32'd3);
      chk("t5_csum_second", 32'(csum_log[base + 1]), 32'(csum16(pb)));
    end

`ifdef IP_CSUM_ARB_UDP_EN
    // 6: UDP zero-checksum substitution
    pa = '{16'hFFFF, 16'h0000};
    base = tid_log.size();
    send_pkt(0, pa, 1'b1, -1, 0, 0);
    wait_results(base + 1);
    send_pkt(0, pa, 1'b0, -1, 0, 0);
    wait_results(base + 2);
    if (tid_log.size() >= base + 2) begin
      chk("t6_udp1", 32'(csum_log[base]), 32'h0000FFFF);
      chk("t6_udp0", 32'(csum_log[base + 1]), 32'h00000000);
    end
`endif

    // random traffic on all lanes
    base = tid_log.size();
    fork
      rand_lane(0);
      rand_lane(1);
      rand_lane(2);
      rand_lane(3);
    join
    wait_results(base + 32);
    chk("rand_all_done", 32'(tid_log.size() - base), 32'd32);
    chk("rand_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
